// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader: memory geometry
// and the loader FSM state encoding.
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1024;

    // Loader FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles four consecutive bytes into one little-endian 32-bit word.
// The first byte lands in [7:0], the fourth in [31:24]. word/word_valid are
// presented combinationally in the same cycle the fourth byte is offered,
// so the caller can capture the full word on that edge.
module byte_to_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  lane;
    logic [23:0] partial;

    // Lane counter and shift register holding the first three bytes of a word.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n || clear) begin
            lane    <= 2'd0;
            partial <= 24'd0;
        end else if (byte_valid) begin
            lane    <= lane + 2'd1;
            partial <= {byte_data, partial[23:8]};
        end
    end

    // Fourth byte completes the word: it goes on top of the three held bytes.
    always_comb begin
        word       = {byte_data, partial};
        word_valid = byte_valid && (lane == 2'd3);
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer. Receives a byte stream (16-bit word
// count header, LSB first, followed by little-endian words), drives the
// memory write port and holds the core in reset until a load completes.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W  = IMEM_ADDR_W,
    parameter int DEPTH   = IMEM_DEPTH,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              WE,
    output logic [ADDR_W-1:0] As,
    output logic [31:0]       WD,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              hdr_byte;     // 0: expecting header LSB, 1: expecting MSB
    logic [7:0]        n_lo;
    logic [15:0]       hdr_n;
    logic              hdr_bad;
    logic [10:0]       n_words;
    logic [10:0]       word_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout_hit;
    logic [31:0]       word;
    logic              word_valid;

    assign accept      = rx_valid && rx_ready;
    assign hdr_n       = {rx_data, n_lo};
    assign hdr_bad     = (hdr_n == 16'd0) || (32'(hdr_n) > DEPTH);
    // Last idle cycle before abort: TIMEOUT consecutive cycles without a byte.
    assign timeout_hit = !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == IDLE),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = HDR;
            HDR: begin
                if (accept && hdr_byte) state_next = hdr_bad ? ERR : DATA;
                else if (timeout_hit)   state_next = ERR;
            end
            DATA: begin
                if (word_valid)       state_next = WRITE;
                else if (timeout_hit) state_next = ERR;
            end
            WRITE:   state_next = (word_cnt == n_words) ? DONE : DATA;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake output depends on state only.
    always_comb begin
        rx_ready = (state == HDR) || (state == DATA);
    end

    // Write port, counters, idle timer and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            WE       <= 1'b0;
            As       <= '0;
            WD       <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            hdr_byte <= 1'b0;
            n_lo     <= 8'd0;
            n_words  <= 11'd0;
            word_cnt <= 11'd0;
            idle_cnt <= '0;
        end else begin
            WE <= (state_next == WRITE);

            unique case (state)
                IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        As       <= '0;
                        word_cnt <= 11'd0;
                        hdr_byte <= 1'b0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        hdr_byte <= 1'b1;
                        if (!hdr_byte) n_lo    <= rx_data;
                        else           n_words <= hdr_n[10:0];
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        WD       <= word;
                        word_cnt <= word_cnt + 11'd1;
                    end
                end
                WRITE:   As <= As + ADDR_W'(1);
                default: ;
            endcase

            // Idle timer runs only while waiting for bytes.
            if (accept || !((state == HDR) || (state == DATA))) idle_cnt <= '0;
            else                                                idle_cnt <= idle_cnt + IDLE_W'(1);

            if (state_next == DONE) begin
                done     <= 1'b1;
                busy     <= 1'b0;
                cpu_hold <= 1'b0;
            end
            if (state_next == ERR) begin
                err  <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads plus hand-written
// sequences for latency, timeout and mid-load reset. A scoreboard queue holds
// the expected (address, data) of every write; a monitor pops it on each WE.
module tb_imem_loader;

    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 1024;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              WE;
    logic [ADDR_W-1:0] As;
    logic [31:0]       WD;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .WE       (WE),
        .As       (As),
        .WD       (WD),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [15:0] n;
        int          off;
        bit          exp_err;
    } vec_t;

    wr_t         exp_q[$];
    logic [31:0] mem [DEPTH];
    int          checks   = 0;
    int          failures = 0;
    int          we_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: model memory plus scoreboard comparison.
    always @(negedge clk) begin
        if (WE === 1'b1) begin
            wr_t e;
            we_count++;
            mem[As] = WD;
            check("we_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("we_addr", 32'(As), 32'(e.addr));
                check("we_data", WD, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int off);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_ready) break;
            n++;
            if (n > 1000) begin
                check("rx_ready_wait", 32'(rx_ready), 32'd1);
                rx_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        if (off > 0) begin
            rx_valid = 1'b0;
            repeat (off) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w, input int off);
        wr_t e;
        e.addr = addr;
        e.data = w;
        exp_q.push_back(e);
        send_byte(w[7:0], off);
        send_byte(w[15:8], off);
        send_byte(w[23:16], off);
        send_byte(w[31:24], off);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 4 * TIMEOUT + 100) begin
                check("end_wait_busy", 32'(busy), 32'd0);
                break;
            end
        end
    endtask

    function automatic logic [31:0] inc_word(input int i);
        return {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
    endfunction

    // mode 0: random words, mode 1: incrementing byte pattern.
    task automatic run_load(input logic [15:0] n, input int off, input bit exp_err, input int mode);
        int we0 = we_count;
        do_start();
        check("start_busy", 32'(busy), 32'd1);
        send_byte(n[7:0], off);
        send_byte(n[15:8], off);
        if (!exp_err) begin
            for (int i = 0; i < int'(n); i++) begin
                send_word(ADDR_W'(i), (mode == 1) ? inc_word(i) : $urandom, off);
            end
        end
        rx_valid = 1'b0;
        wait_end();
        check("load_done", 32'(done), 32'(!exp_err));
        check("load_err", 32'(err), 32'(exp_err));
        check("load_cpu_hold", 32'(cpu_hold), 32'(exp_err));
        check("load_we_count", 32'(we_count - we0), exp_err ? 32'd0 : 32'(n));
        check("load_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t vecs[7];
        int   we0;

        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   we0;

        vecs[0] = '{n: 16'd0,     off: 0, exp_err: 1'b1};
        vecs[1] = '{n: 16'd1025,  off: 0, exp_err: 1'b1};
        vecs[2] = '{n: 16'hFFFF,  off: 1, exp_err: 1'b1};
        vecs[3] = '{n: 16'd1,     off: 0, exp_err: 1'b0};
        vecs[4] = '{n: 16'd3,     off: 1, exp_err: 1'b0};
        vecs[5] = '{n: 16'd5,     off: 3, exp_err: 1'b0};
        vecs[6] = '{n: 16'd2,     off: 2, exp_err: 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_we", 32'(WE), 32'd0);
        check("rst_as", 32'(As), 32'd0);
        check("rst_wd", WD, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        rst_n = 1'b1;

        // Two-word program with rx_valid held high; check write/done latency.
        do_start();
        exp_q.push_back('{addr: 10'd0, data: 32'h00A00513});
        exp_q.push_back('{addr: 10'd1, data: 32'h00100593});
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        send_byte(8'hA0, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h05, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("lat_we", 32'(WE), 32'd1);
        check("lat_as", 32'(As), 32'd1);
        check("lat_wd", WD, 32'h00100593);
        check("lat_done_low", 32'(done), 32'd0);
        @(negedge clk);
        check("lat_done", 32'(done), 32'd1);
        check("lat_busy", 32'(busy), 32'd0);
        check("lat_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Same stream with 1-on/3-off valid, plus a start pulse mid-load.
        we0 = we_count;
        do_start();
        exp_q.push_back('{addr: 10'd0, data: 32'h00A00513});
        exp_q.push_back('{addr: 10'd1, data: 32'h00100593});
        send_byte(8'h02, 3);
        send_byte(8'h00, 3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_start_ignored_as", 32'(As), 32'd0);
        send_word(10'd0, 32'h00A00513, 3);
        void'(exp_q.pop_back());
        send_word(10'd1, 32'h00100593, 3);
        void'(exp_q.pop_back());
        wait_end();
        check("t2_done", 32'(done), 32'd1);
        check("t2_we_count", 32'(we_count - we0), 32'd2);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Table of loads: bad headers and short loads at several valid rates.
        for (int i = 0; i < 7; i++) begin
            run_load(vecs[i].n, vecs[i].off, vecs[i].exp_err, 0);
        end

        // Timeout with a partial word outstanding.
        we0 = we_count;
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        rx_valid = 1'b0;
        repeat (TIMEOUT - 4) @(negedge clk);
        check("to_still_busy", 32'(busy), 32'd1);
        wait_end();
        check("to_err", 32'(err), 32'd1);
        check("to_done", 32'(done), 32'd0);
        check("to_cpu_hold", 32'(cpu_hold), 32'd1);
        check("to_no_we", 32'(we_count - we0), 32'd0);

        // Full-depth load; address wraps to 0 at completion.
        run_load(16'd1024, 0, 1'b0, 1);
        check("full_as_wrap", 32'(As), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            check("readback", mem[i], inc_word(i));
        end

        // Reset during the third word; start asserted with reset must lose.
        do_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_word(10'd0, 32'h11223344, 0);
        send_word(10'd1, 32'h55667788, 0);
        send_byte(8'h99, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        check("mid_rst_we", 32'(WE), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(rx_ready), 32'd0);
        check("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("mid_rst_as", 32'(As), 32'd0);
        check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        run_load(16'd2, 0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
